// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared constants and small helpers for the mesh NoC router datapath.
//   FLIT_WIDTH : default flit width in bits
//   FIFO_DEPTH : default flit buffer depth in words
//   fifo_op_e  : the push/pop combination a FIFO performs on a given edge
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int FLIT_WIDTH = 18;
    localparam int FIFO_DEPTH = 64;

    // Encoded as {push, pop} so the decode below is a plain cast.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Register-array storage for sync_fifo: synchronous write, asynchronous read.
// Ports:
//   clk   : write clock (rising edge)
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data at raddr
// -----------------------------------------------------------------------------
module fifo_mem
    import noc_pkg::*;
#(
    parameter int WIDTH  = FLIT_WIDTH,
    parameter int LENGTH = FIFO_DEPTH,
    parameter int AW     = $clog2(LENGTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [LENGTH];

    // NOTE: the array has no reset; the controller never exposes an unwritten
    // word, and leaving it out keeps this mappable onto plain register/RAM cells.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead (first-word fall-through) FIFO used as the flit
// buffer in the NoC router ports. The head word is presented on data_out with
// zero latency; full/empty are decoded from the registered occupancy count so
// they have no combinational path from read/write.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset (clears pointers and count only)
//   write    : push request, ignored when full unless read is also accepted
//   read     : pop request, ignored when empty
//   data_in  : word to push
//   data_out : current head word, zero when empty
//   full     : LENGTH words held
//   empty    : no words held
// -----------------------------------------------------------------------------
module sync_fifo
    import noc_pkg::*;
#(
    parameter int WIDTH  = FLIT_WIDTH,
    parameter int LENGTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write,
    input  logic             read,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(LENGTH);
    localparam int CNT_W = $clog2(LENGTH + 1);

    // Explicit wrap point so LENGTH need not be a power of two.
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(LENGTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(LENGTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] head_word;
    fifo_op_e         op;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    // A write into a full FIFO is still accepted when a read frees the head
    // slot on the same edge.
    assign wr_en = write & (~full | read);
    assign rd_en = read & ~empty;
    assign op    = fifo_op(wr_en, rd_en);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            end
            case (op)
                FIFO_PUSH: count <= count + CNT_ONE;
                FIFO_POP:  count <= count - CNT_ONE;
                default:   count <= count;
            endcase
        end
    end

    fifo_mem #(
        .WIDTH  (WIDTH),
        .LENGTH (LENGTH),
        .AW     (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (head_word)
    );

    // Masking keeps stale or never-written storage off the output while empty.
    assign data_out = empty ? '0 : head_word;

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
// Self-checking bench for sync_fifo. A queue holds the expected contents;
// every accepted push/pop is applied to it from the FIFO rules, and the
// expected full/empty/data_out are derived from its size and front element.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int W     = 18;
    localparam int DEPTH = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         write = 1'b0;
    logic         read = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] data_out;
    logic         full;
    logic         empty;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] model_q [$];
    logic [W-1:0] fill_words [DEPTH];

    sync_fifo #(
        .WIDTH  (W),
        .LENGTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .write    (write),
        .read     (read),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    initial begin
        forever begin
            #5 clk = 1'b1;
            #5 clk = 1'b0;
        end
    end

    // Expected {full, empty, data_out} from the queue contents.
    function automatic logic [W+1:0] expected_outs();
        logic [W-1:0] head;
        head = (model_q.size() != 0) ? model_q[0] : '0;
        return {model_q.size() == DEPTH, model_q.size() == 0, head};
    endfunction

    // One clock of stimulus; the queue follows the accept rules at the edge.
    task automatic step(input logic w, input logic r, input logic [W-1:0] d);
        bit wr_acc;
        bit rd_acc;
        write   = w;
        read    = r;
        data_in = d;
        @(posedge clk);
        wr_acc = w && ((model_q.size() < DEPTH) || r);
        rd_acc = r && (model_q.size() != 0);
        if (rd_acc) void'(model_q.pop_front());
        if (wr_acc) model_q.push_back(d);
        #1;
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic test_reset();
        #6 rst = 1'b0;
        #2;
        n_checks++;
        if ({full, empty, data_out} !== {1'b0, 1'b1, {W{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_async: got full=%b empty=%b dout=%h, want full=0 empty=1 dout=0",
                     full, empty, data_out);
        end
        #3 rst = 1'b1;
        model_q.delete();
        step(1'b0, 1'b1, W'($urandom));
        n_checks++;
        if ({full, empty, data_out} !== {1'b0, 1'b1, {W{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_read_empty: got full=%b empty=%b dout=%h, want full=0 empty=1 dout=0",
                     full, empty, data_out);
        end
    endtask

    task automatic test_fill();
        logic [W-1:0] extra;
        for (int i = 0; i < DEPTH; i++) begin
            fill_words[i] = W'($urandom);
            step(1'b1, 1'b0, fill_words[i]);
            n_checks++;
            if ({full, empty, data_out} !== expected_outs()) begin
                n_fail++;
                $display("FAIL fill_%0d: got %b_%b_%h, want %h", i, full, empty, data_out, expected_outs());
            end
            if (i == 0) begin
                n_checks++;
                if (empty !== 1'b0 || data_out !== fill_words[0]) begin
                    n_fail++;
                    $display("FAIL fill_first: got empty=%b dout=%h, want empty=0 dout=%h",
                             empty, data_out, fill_words[0]);
                end
            end
        end
        n_checks++;
        if (full !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_full: got full=%b, want 1", full);
        end
        extra = ~fill_words[0];
        step(1'b1, 1'b0, extra);
        n_checks++;
        if (full !== 1'b1 || data_out !== fill_words[0] || model_q.size() != DEPTH) begin
            n_fail++;
            $display("FAIL fill_overflow: got full=%b dout=%h, want full=1 dout=%h",
                     full, data_out, fill_words[0]);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (data_out !== fill_words[i]) begin
                n_fail++;
                $display("FAIL drain_%0d: got dout=%h, want %h", i, data_out, fill_words[i]);
            end
            step(1'b0, 1'b1, '0);
        end
        n_checks++;
        if ({full, empty, data_out} !== {1'b0, 1'b1, {W{1'b0}}}) begin
            n_fail++;
            $display("FAIL drain_empty: got full=%b empty=%b dout=%h, want 0 1 0", full, empty, data_out);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, W'($urandom));
            n_checks++;
            if ({full, empty, data_out} !== expected_outs()) begin
                n_fail++;
                $display("FAIL underflow_%0d: got %b_%b_%h, want %h", i, full, empty, data_out, expected_outs());
            end
        end
    endtask

    task automatic test_wrap();
        int phase_len [4] = '{40, 30, 50, 60};
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < phase_len[p]; i++) begin
                step(p[0] == 1'b0, p[0] == 1'b1, W'($urandom));
                n_checks++;
                if ({full, empty, data_out} !== expected_outs() || full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wrap_p%0d_%0d: got %b_%b_%h, want %h", p, i, full, empty, data_out,
                             expected_outs());
                end
            end
        end
        n_checks++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_end_empty: got empty=%b, want 1", empty);
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] new_word;
        logic [W-1:0] second;
        logic [W-1:0] solo;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, W'($urandom));
        end
        second   = model_q[1];
        new_word = W'($urandom);
        step(1'b1, 1'b1, new_word);
        n_checks++;
        if (full !== 1'b1 || data_out !== second) begin
            n_fail++;
            $display("FAIL full_rw: got full=%b dout=%h, want full=1 dout=%h", full, data_out, second);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) begin
                n_checks++;
                if (data_out !== new_word) begin
                    n_fail++;
                    $display("FAIL full_rw_last: got dout=%h, want %h", data_out, new_word);
                end
            end
            step(1'b0, 1'b1, '0);
            n_checks++;
            if ({full, empty, data_out} !== expected_outs()) begin
                n_fail++;
                $display("FAIL full_rw_drain_%0d: got %b_%b_%h, want %h", i, full, empty, data_out,
                         expected_outs());
            end
        end
        solo = W'($urandom);
        step(1'b1, 1'b1, solo);
        n_checks++;
        if (empty !== 1'b0 || full !== 1'b0 || data_out !== solo) begin
            n_fail++;
            $display("FAIL empty_rw: got empty=%b full=%b dout=%h, want 0 0 %h", empty, full, data_out, solo);
        end
        step(1'b0, 1'b1, '0);
        n_checks++;
        if (empty !== 1'b1 || data_out !== '0) begin
            n_fail++;
            $display("FAIL empty_rw_count1: got empty=%b dout=%h, want empty=1 dout=0", empty, data_out);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, W'($urandom));
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({full, empty, data_out} !== {1'b0, 1'b1, {W{1'b0}}}) begin
            n_fail++;
            $display("FAIL mid_reset: got full=%b empty=%b dout=%h, want 0 1 0", full, empty, data_out);
        end
        #1 rst = 1'b1;
        model_q.delete();
        step(1'b1, 1'b0, 18'h2A5F0);
        n_checks++;
        if (empty !== 1'b0 || data_out !== 18'h2A5F0) begin
            n_fail++;
            $display("FAIL mid_reset_write: got empty=%b dout=%h, want empty=0 dout=2a5f0", empty, data_out);
        end
        step(1'b0, 1'b1, '0);
    endtask

    task automatic test_random();
        int wr_bias;
        for (int i = 0; i < 600; i++) begin
            // Alternate write-heavy and read-heavy stretches to reach both ends.
            wr_bias = ((i / 150) % 2 == 0) ? 75 : 30;
            step($urandom_range(0, 99) < wr_bias, $urandom_range(0, 99) < 100 - wr_bias + 5,
                 W'($urandom));
            n_checks++;
            if ({full, empty, data_out} !== expected_outs()) begin
                n_fail++;
                $display("FAIL random_%0d: got %b_%b_%h, want %h", i, full, empty, data_out, expected_outs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, parameterised first-in first-out buffer with show-ahead (first-word fall-through) output.
- Used as the flit buffer in the mesh NoC router input and output ports; default geometry holds 64 words of 18 bits.
- Provides full/empty status so the upstream writer and downstream reader can throttle themselves.

Parameters:
- WIDTH, 18, data word width in bits (>=1).
- LENGTH, 64, storage depth in words (>=2; need not be a power of two).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- write  in  1  push request; data_in is stored on a rising clk edge when accepted.
- read  in  1  pop request; the head word is removed on a rising clk edge when accepted.
- data_in  in  WIDTH  word to push.
- data_out  out  WIDTH  current head word (show-ahead).
- full  out  1  high when the FIFO holds LENGTH words.
- empty  out  1  high when the FIFO holds 0 words.

Behaviour:
- Reset (rst low, asynchronous, independent of clk): wr_ptr=0, rd_ptr=0, count=0. Outputs go immediately to empty=1, full=0, data_out=0. Storage array contents are not cleared. Reset asserted mid-operation discards all stored words.
- Internal state: wr_ptr and rd_ptr, each $clog2(LENGTH) bits; count, $clog2(LENGTH+1) bits; memory of LENGTH x WIDTH.
- Accept rules, evaluated each rising edge:
  - wr_en = write & (~full | read).
  - rd_en = read & ~empty.
- Write when full with no read: ignored; data_in is dropped and no state changes.
- Read when empty: ignored. A simultaneous write while empty is still accepted.
- Simultaneous read+write when full: both accepted; count stays at LENGTH.
- Simultaneous read+write when 0<count<LENGTH: both accepted; count unchanged.
- On wr_en: mem[wr_ptr] <= data_in. wr_ptr advances by 1, wrapping from LENGTH-1 to 0.
- On rd_en: rd_ptr advances by 1 with the same wrap rule.
- count update: +1 on wr_en only, -1 on rd_en only, unchanged otherwise.
- full = (count == LENGTH) and empty = (count == 0). Both are decoded from registered count, so no combinational path from read/write.
- data_out is combinational: mem[rd_ptr] when count != 0, else all zeros.
  - Zero-cycle latency from head to output.
  - A word written at edge N is visible on data_out after edge N if the FIFO was empty.
  - After an accepted read at edge N, data_out shows the next word after edge N.
- No overflow/underflow flags. Misuse is silently ignored as described above.

Decomposition:
- Shared package noc_pkg: default FLIT_WIDTH=18 and FIFO_DEPTH=64 constants, plus a clog2 helper function if the toolchain lacks $clog2.
- Optional sub-module fifo_mem (synchronous-write, asynchronous-read register array, WIDTH x LENGTH). Pointer/count control stays in sync_fifo.

Test Plan:
- Reset: pulse rst low for 5 ns with no clock edge -> empty=1, full=0, data_out=0 immediately. Then read=1 for one cycle -> empty stays 1, pointers unchanged.
- Fill: 64 consecutive writes of random 18-bit values -> after write 1, empty=0 and data_out=word0. After write 64, full=1. A 65th write with a different value is dropped: full stays 1 and data_out stays word0.
- Drain: 64 consecutive reads -> at each rising edge, data_out equals word i in write order. After read 64, empty=1 and data_out=0. Further reads do nothing.
- Wrap-around: write 40, read 30, write 50 (count=60), then read 60 -> output sequence matches write order across the pointer wrap. full never asserts. empty asserts only at the end.
- Simultaneous ops:
  - When full, read+write one cycle -> full stays 1, head advances, and the new word becomes the 64th entry.
  - When empty, read+write -> the word is stored, empty=0, and count=1.
- Mid-operation reset: with 10 words stored, assert rst between edges -> empty=1 and data_out=0 immediately. A subsequent write of 0x2A5F0 gives data_out=0x2A5F0.
